i2c_master_ctrl: RTL

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_master_ctrl.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i2c_master_ctrl
// Brief    : Open-drain I2C master for single-register write / read transfers.
// Revision : 1.0
// ============================================================================
module i2c_master_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [4:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata,
    inout  tri1        scl,
    inout  tri1        sda
);

    localparam int              C_CW       = $clog2(DIV);
    localparam logic [C_CW-1:0] C_DIV_LAST = C_CW'(DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_START  = 4'd1,
        S_ADDR_W = 4'd2,
        S_REG    = 4'd3,
        S_WDATA  = 4'd4,
        S_RSTART = 4'd5,
        S_ADDR_R = 4'd6,
        S_RDATA  = 4'd7,
        S_STOP   = 4'd8
    } state_t;

    state_t          state_q,   state_d;
    logic [C_CW-1:0] div_q,     div_d;
    logic [1:0]      phase_q,   phase_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shreg_q,   shreg_d;
    logic            nack_q,    nack_d;
    logic            err_q,     err_d;
    logic            rw_q,      rw_d;
    logic [6:0]      dev_q,     dev_d;
    logic [4:0]      reg_q,     reg_d;
    logic [7:0]      wdata_q,   wdata_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;
    logic            ack_err_q, ack_err_d;
    logic [7:0]      rdata_q,   rdata_d;
    logic            scl_low_q, scl_low_d;
    logic            sda_low_q, sda_low_d;

    logic w_tick;
    logic w_sda_in;

    assign w_tick   = (div_q == C_DIV_LAST);
    assign w_sda_in = sda;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        nack_d    = nack_q;
        err_d     = err_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;

        if (state_q == S_IDLE) begin
            // A start coinciding with the done pulse is dropped, not queued.
            if (start && !done_q) begin
                state_d   = S_START;
                div_d     = '0;
                phase_d   = 2'd0;
                bit_cnt_d = 4'd0;
                err_d     = 1'b0;
                rw_d      = rw;
                dev_d     = dev_addr;
                reg_d     = reg_addr;
                wdata_d   = wdata;
                busy_d    = 1'b1;
            end
        end else begin
            div_d = w_tick ? '0 : div_q + 1'b1;
            if (w_tick) begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd2) begin
                    if (bit_cnt_q == 4'd8) begin
                        nack_d = w_sda_in;
                    end else if (state_q == S_RDATA) begin
                        shreg_d = {shreg_q[6:0], w_sda_in};
                    end
                end
                if (phase_q == 2'd3) begin
                    case (state_q)
                        S_START: begin
                            state_d   = S_ADDR_W;
                            bit_cnt_d = 4'd0;
                            shreg_d   = {dev_q, 1'b0};
                        end
                        S_RSTART: begin
                            state_d   = S_ADDR_R;
                            bit_cnt_d = 4'd0;
                            shreg_d   = {dev_q, 1'b1};
                        end
                        S_STOP: begin
                            state_d   = S_IDLE;
                            done_d    = 1'b1;
                            busy_d    = 1'b0;
                            ack_err_d = err_q;
                            if (rw_q && !err_q) begin
                                rdata_d = shreg_q;
                            end
                        end
                        default: begin
                            if (bit_cnt_q == 4'd8) begin
                                bit_cnt_d = 4'd0;
                                // Our own NACK after the read byte is not an error.
                                if (nack_q && state_q != S_RDATA) begin
                                    err_d   = 1'b1;
                                    state_d = S_STOP;
                                end else begin
                                    case (state_q)
                                        S_ADDR_W: begin
                                            state_d = S_REG;
                                            shreg_d = {3'b000, reg_q};
                                        end
                                        S_REG: begin
                                            state_d = rw_q ? S_RSTART : S_WDATA;
                                            shreg_d = wdata_q;
                                        end
                                        S_ADDR_R: state_d = S_RDATA;
                                        default:  state_d = S_STOP;
                                    endcase
                                end
                            end else begin
                                bit_cnt_d = bit_cnt_q + 4'd1;
                                if (state_q != S_RDATA) begin
                                    shreg_d = {shreg_q[6:0], 1'b0};
                                end
                            end
                        end
                    endcase
                end
            end
        end

        // Bus levels follow the next phase so pins change exactly on phase edges.
        scl_low_d = 1'b0;
        sda_low_d = 1'b0;
        case (state_d)
            S_IDLE: ;
            S_START, S_RSTART: begin
                scl_low_d = (phase_d == 2'd3) || (phase_d == 2'd0 && state_d == S_RSTART);
                sda_low_d = (phase_d == 2'd2) || (phase_d == 2'd3);
            end
            S_STOP: begin
                scl_low_d = (phase_d == 2'd0);
                sda_low_d = (phase_d == 2'd0) || (phase_d == 2'd1);
            end
            default: begin
                scl_low_d = (phase_d == 2'd0) || (phase_d == 2'd3);
                sda_low_d = (bit_cnt_d != 4'd8) && (state_d != S_RDATA) && !shreg_d[7];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            phase_q   <= 2'd0;
            bit_cnt_q <= 4'd0;
            shreg_q   <= 8'h00;
            nack_q    <= 1'b0;
            err_q     <= 1'b0;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 5'h00;
            wdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'h00;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            nack_q    <= nack_d;
            err_q     <= err_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;
    assign scl     = scl_low_q ? 1'b0 : 1'bz;
    assign sda     = sda_low_q ? 1'b0 : 1'bz;

endmodule
`default_nettype wire
